// File: rtl/ethernet_icmp_header_parser_pkg.sv
// Shared constants, state encoding and byte/word helpers for the ICMP header parser.
// Byte k of a 64-bit beat sits at tdata[8k+7:8k]; byte 0 is first on the wire.
package ethernet_icmp_header_parser_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_ICMP    = 8'h01;
  localparam logic [7:0]  ICMP_ECHO_REQ    = 8'd8;
  localparam logic [7:0]  ICMP_ECHO_CODE   = 8'd0;

  localparam logic [2:0]  HDR_BEAT_FIRST   = 3'd0;
  localparam logic [2:0]  HDR_BEAT_ETHTYPE = 3'd1;
  localparam logic [2:0]  HDR_BEAT_PROTO   = 3'd2;
  localparam logic [2:0]  HDR_BEAT_ICMP    = 3'd4;
  localparam logic [2:0]  BEAT_CNT_MAX     = 3'd5;

  localparam logic [7:0]  KEEP_ALL         = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2,
    TAIL    = 2'd3
  } state_t;

  function automatic logic [7:0] beat_byte(input logic [63:0] data, input logic [2:0] idx);
    beat_byte = data[{idx, 3'b000} +: 8];
  endfunction

  // Network-order 16-bit word k of a beat: {byte 2k, byte 2k+1}.
  function automatic logic [15:0] beat_word(input logic [63:0] data, input logic [1:0] k);
    beat_word = {beat_byte(data, {k, 1'b0}), beat_byte(data, {k, 1'b1})};
  endfunction

endpackage

// File: rtl/ethernet_icmp_seed_sum.sv
// Beat-4 seed adder: sums the ICMP type/code, checksum and identifier words
// (frame bytes 34..39 = beat bytes 2..7) into a 21-bit partial sum.
module ethernet_icmp_seed_sum
  import ethernet_icmp_header_parser_pkg::*;
#(
  parameter bit ZERO_CSUM_FIELD = 1'b1
) (
  input  logic [63:0] i_tdata,
  output logic [20:0] o_sum
);

  logic [15:0] w_type_code;
  logic [15:0] w_csum;
  logic [15:0] w_ident;

  assign w_type_code = beat_word(i_tdata, 2'd1);
  // The checksum field is treated as zero so the downstream accumulator can compute it.
  assign w_csum      = ZERO_CSUM_FIELD ? 16'h0000 : beat_word(i_tdata, 2'd2);
  assign w_ident     = beat_word(i_tdata, 2'd3);

  assign o_sum = {5'd0, w_type_code} + {5'd0, w_csum} + {5'd0, w_ident};

endmodule

// File: rtl/ethernet_icmp_header_parser.sv
// Qualifies Ethernet/IPv4(IHL=5)/ICMP frames on a 64-bit RX stream and drives the
// checksum accumulator's valid window, beat-4 seed sum and beat-5 seed strobe.
module ethernet_icmp_header_parser
  import ethernet_icmp_header_parser_pkg::*;
#(
  parameter bit ECHO_ONLY       = 1'b1,
  parameter bit ZERO_CSUM_FIELD = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [63:0]      i_rx_axis_tdata,
  input  logic             i_rx_axis_tvalid,
  input  logic             i_rx_axis_tlast,
  input  logic [7:0]       i_rx_axis_tkeep,
  output logic             o_icmp_valid,
  output logic [20:0]      o_icmp_crc_part1,
  output logic             o_icmp_crc_part1_ready,
  output logic [7:0]       o_icmp_type,
  output logic [7:0]       o_icmp_code,
  output logic [CNT_W-1:0] o_icmp_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_beat_cnt;
  logic [2:0]       w_beat_cnt_nxt;
  logic [2:0]       w_beat_cnt_inc;
  logic             r_ok;
  logic             r_pending;
  logic             r_icmp_valid;
  logic [20:0]      r_part1;
  logic [7:0]       r_type;
  logic [7:0]       r_code;
  logic [CNT_W-1:0] r_icmp_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [20:0]      w_seed_sum;
  logic [15:0]      w_ethtype;
  logic [7:0]       w_icmp_type;
  logic [7:0]       w_icmp_code;
  logic             w_beat_ok;
  logic             w_hdr_ok;
  logic             w_hdr_beat;
  logic             w_seed_load;
  logic             w_drop_evt;
  logic             w_payload_beat;

  ethernet_icmp_seed_sum #(
    .ZERO_CSUM_FIELD (ZERO_CSUM_FIELD)
  ) u_seed_sum (
    .i_tdata (i_rx_axis_tdata),
    .o_sum   (w_seed_sum)
  );

  assign w_ethtype      = beat_word(i_rx_axis_tdata, 2'd2);
  assign w_icmp_type    = beat_byte(i_rx_axis_tdata, 3'd2);
  assign w_icmp_code    = beat_byte(i_rx_axis_tdata, 3'd3);
  assign w_beat_cnt_inc = (r_beat_cnt >= BEAT_CNT_MAX) ? BEAT_CNT_MAX : (r_beat_cnt + 3'd1);
  assign w_hdr_beat     = i_rx_axis_tvalid && ((r_state == IDLE) || (r_state == TAIL));

  // Per-beat header field check, selected by the beat index.
  always_comb begin
    w_beat_ok = 1'b1;
    case (r_beat_cnt)
      HDR_BEAT_ETHTYPE: w_beat_ok = (w_ethtype == ETH_TYPE_IPV4) &&
                                    (beat_byte(i_rx_axis_tdata, 3'd6) == IPV4_VER_IHL);
      HDR_BEAT_PROTO:   w_beat_ok = (beat_byte(i_rx_axis_tdata, 3'd7) == IP_PROTO_ICMP);
      HDR_BEAT_ICMP:    w_beat_ok = (i_rx_axis_tkeep == KEEP_ALL) &&
                                    (!ECHO_ONLY || ((w_icmp_type == ICMP_ECHO_REQ) &&
                                                    (w_icmp_code == ICMP_ECHO_CODE)));
      default:          w_beat_ok = 1'b1;
    endcase
  end

  // Beat 0 restarts the sticky flag; later header beats can only clear it.
  assign w_hdr_ok = (r_beat_cnt == HDR_BEAT_FIRST) ? w_beat_ok : (r_ok && w_beat_ok);

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_seed_load    = 1'b0;
    w_drop_evt     = 1'b0;
    w_payload_beat = 1'b0;
    case (r_state)
      // TAIL holds for one cycle; a beat accepted in it is beat 0 of the next frame.
      IDLE, TAIL: begin
        w_state_nxt = IDLE;
        if (i_rx_axis_tvalid) begin
          if (r_beat_cnt == HDR_BEAT_ICMP) begin
            w_beat_cnt_nxt = w_beat_cnt_inc;
            if (w_hdr_ok && !i_rx_axis_tlast) begin
              w_state_nxt = PAYLOAD;
              w_seed_load = 1'b1;
            end else if (i_rx_axis_tlast) begin
              w_drop_evt     = 1'b1;
              w_beat_cnt_nxt = 3'd0;
            end else begin
              w_state_nxt = DROP;
            end
          end else if (i_rx_axis_tlast) begin
            w_drop_evt     = 1'b1;
            w_beat_cnt_nxt = 3'd0;
          end else begin
            w_beat_cnt_nxt = w_beat_cnt_inc;
          end
        end else begin
          w_beat_cnt_nxt = r_beat_cnt;
        end
      end
      PAYLOAD: begin
        if (i_rx_axis_tvalid) begin
          w_payload_beat = 1'b1;
          if (i_rx_axis_tlast) begin
            w_state_nxt    = TAIL;
            w_beat_cnt_nxt = 3'd0;
          end else begin
            w_beat_cnt_nxt = w_beat_cnt_inc;
          end
        end else begin
          w_state_nxt = PAYLOAD;
        end
      end
      DROP: begin
        if (i_rx_axis_tvalid && i_rx_axis_tlast) begin
          w_state_nxt    = IDLE;
          w_drop_evt     = 1'b1;
          w_beat_cnt_nxt = 3'd0;
        end else if (i_rx_axis_tvalid) begin
          w_beat_cnt_nxt = w_beat_cnt_inc;
        end else begin
          w_state_nxt = DROP;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_beat_cnt_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_beat_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ok         <= 1'b0;
      r_pending    <= 1'b0;
      r_icmp_valid <= 1'b0;
      r_part1      <= 21'd0;
      r_type       <= 8'd0;
      r_code       <= 8'd0;
      r_icmp_cnt   <= {CNT_W{1'b0}};
      r_drop_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (w_hdr_beat) begin
        r_ok <= w_hdr_ok;
      end
      if (w_seed_load) begin
        r_pending <= 1'b1;
      end else if (w_payload_beat) begin
        r_pending <= 1'b0;
      end
      // Seed and captured type/code stay put until the next qualifying frame.
      if (w_seed_load) begin
        r_part1    <= w_seed_sum;
        r_type     <= w_icmp_type;
        r_code     <= w_icmp_code;
        r_icmp_cnt <= r_icmp_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_drop_evt) begin
        r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      r_icmp_valid <= (w_state_nxt == PAYLOAD) || (w_state_nxt == TAIL);
    end
  end

  assign o_icmp_valid           = r_icmp_valid;
  assign o_icmp_crc_part1       = r_part1;
  // Combinational so the strobe lines up with beat 5 on the bus even after tvalid gaps.
  assign o_icmp_crc_part1_ready = r_pending & i_rx_axis_tvalid;
  assign o_icmp_type            = r_type;
  assign o_icmp_code            = r_code;
  assign o_icmp_cnt             = r_icmp_cnt;
  assign o_drop_cnt             = r_drop_cnt;

endmodule

// File: tb/tb_ethernet_icmp_header_parser.sv
// Scoreboard bench for ethernet_icmp_header_parser: directed frames push expected seed
// strobes, valid-window lengths and drop counts; a monitor pops and compares them.
module tb_ethernet_icmp_header_parser;

  typedef struct {
    logic [15:0] ethtype;
    logic [7:0]  ver;
    logic [7:0]  proto;
    logic [47:0] icmp;
    int          nbeats;
    int          gap4;
    logic [7:0]  keep4;
    bit          exp_ok;
    logic [20:0] exp_part1;
    bit          b2b;
  } vec_t;

  typedef struct {
    logic [20:0] part1;
    logic [7:0]  typ;
    logic [7:0]  code;
    logic [15:0] icnt;
  } seed_t;

  logic        clk;
  logic        rst;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic [7:0]  tkeep;
  logic        icmp_valid;
  logic [20:0] part1;
  logic        part1_ready;
  logic [7:0]  icmp_type;
  logic [7:0]  icmp_code;
  logic [15:0] icmp_cnt;
  logic [15:0] drop_cnt;

  int    n_vec = 0;
  int    n_err = 0;
  int    exp_icmp = 0;
  int    exp_drop = 0;
  bit    rst_window = 1'b0;
  seed_t q_seed[$];
  int    q_win[$];
  int    q_drop[$];
  vec_t  vecs[$];

  ethernet_icmp_header_parser #(
    .ECHO_ONLY       (1'b1),
    .ZERO_CSUM_FIELD (1'b1),
    .CNT_W           (16)
  ) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_rx_axis_tdata        (tdata),
    .i_rx_axis_tvalid       (tvalid),
    .i_rx_axis_tlast        (tlast),
    .i_rx_axis_tkeep        (tkeep),
    .o_icmp_valid           (icmp_valid),
    .o_icmp_crc_part1       (part1),
    .o_icmp_crc_part1_ready (part1_ready),
    .o_icmp_type            (icmp_type),
    .o_icmp_code            (icmp_code),
    .o_icmp_cnt             (icmp_cnt),
    .o_drop_cnt             (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [15:0] et, input logic [7:0] ver, input logic [7:0] pr,
                               input logic [47:0] icmp, input int nb, input int gap,
                               input logic [7:0] keep, input bit ok, input logic [20:0] p1,
                               input bit b2b);
    vec_t v;
    v.ethtype = et; v.ver = ver; v.proto = pr; v.icmp = icmp; v.nbeats = nb;
    v.gap4 = gap; v.keep4 = keep; v.exp_ok = ok; v.exp_part1 = p1; v.b2b = b2b;
    return v;
  endfunction

  function automatic logic [63:0] make_beat(input int k, input vec_t v);
    logic [63:0] d;
    d = 64'h0123_4567_89AB_CDEF ^ {56'h0, 8'(k)};
    if (k == 1) begin
      d[39:32] = v.ethtype[15:8];
      d[47:40] = v.ethtype[7:0];
      d[55:48] = v.ver;
    end
    if (k == 2) d[63:56] = v.proto;
    if (k == 4) for (int j = 0; j < 6; j++) d[16+8*j +: 8] = v.icmp[40-8*j +: 8];
    return d;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [7:0] keep);
    tdata = d; tvalid = 1'b1; tlast = last; tkeep = keep;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_frame(input vec_t v);
    seed_t s;
    if (v.exp_ok) begin
      exp_icmp++;
      s.part1 = v.exp_part1; s.typ = v.icmp[47:40]; s.code = v.icmp[39:32];
      s.icnt = 16'(exp_icmp);
      q_seed.push_back(s);
      q_win.push_back(v.nbeats - 4 + v.gap4);
    end else begin
      exp_drop++;
      q_drop.push_back(exp_drop);
    end
  endtask

  task automatic send_frame(input vec_t v);
    for (int k = 0; k < v.nbeats; k++) begin
      send_beat(make_beat(k, v), k == v.nbeats - 1, (k == 4) ? v.keep4 : 8'hFF);
      if (k == 4 && v.gap4 > 0) idle(v.gap4);
    end
    if (!v.b2b) idle(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(icmp_valid), 32'd0);
    check({tag, "_part1"}, 32'(part1), 32'd0);
    check({tag, "_ready"}, 32'(part1_ready), 32'd0);
    check({tag, "_type"}, 32'(icmp_type), 32'd0);
    check({tag, "_code"}, 32'(icmp_code), 32'd0);
    check({tag, "_icmp_cnt"}, 32'(icmp_cnt), 32'd0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  // Monitor: seed strobes, valid windows and drop-counter steps against the queues.
  initial begin
    int         win_len = 0;
    logic       prev_valid = 1'b0;
    logic [15:0] prev_drop = 16'd0;
    seed_t      s;
    forever begin
      @(negedge clk);
      if (part1_ready === 1'b1) begin
        if (q_seed.size() == 0) begin
          check("unexpected_seed_strobe", 32'd1, 32'd0);
        end else begin
          s = q_seed.pop_front();
          check("seed_part1", 32'(part1), 32'(s.part1));
          check("seed_type", 32'(icmp_type), 32'(s.typ));
          check("seed_code", 32'(icmp_code), 32'(s.code));
          check("seed_icmp_cnt", 32'(icmp_cnt), 32'(s.icnt));
        end
      end
      if (icmp_valid === 1'b1) begin
        win_len++;
      end else if (prev_valid === 1'b1) begin
        if (q_win.size() == 0) check("unexpected_valid_window", 32'(win_len), 32'd0);
        else check("valid_window_len", 32'(win_len), 32'(q_win.pop_front()));
        win_len = 0;
      end
      prev_valid = icmp_valid;
      if (drop_cnt !== prev_drop && !rst_window) begin
        if (q_drop.size() == 0) check("unexpected_drop", 32'(drop_cnt), 32'(prev_drop));
        else check("drop_cnt_step", 32'(drop_cnt), 32'(q_drop.pop_front()));
      end
      prev_drop = drop_cnt;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; tdata = 64'd0; tvalid = 1'b0; tlast = 1'b0; tkeep = 8'hFF;
    idle(3);
    rst = 1'b0;
    check_all_zero("reset");

    //                 ethtype   ver    proto  icmp bytes 34..39     nb gap keep   ok p1        b2b
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h01, 48'h0800_F7FF_0001, 8, 0, 8'hFF, 1, 21'h00801, 0));
    vecs.push_back(mkv(16'h86DD, 8'h45, 8'h01, 48'h0800_F7FF_0001, 8, 0, 8'hFF, 0, 21'h0, 0));
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h06, 48'h0800_F7FF_0001, 8, 0, 8'hFF, 0, 21'h0, 0));
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h01, 48'h0800_F7FF_0001, 4, 0, 8'hFF, 0, 21'h0, 0));
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h01, 48'h0800_1234_ABCD, 7, 0, 8'hFF, 1, 21'h0B3CD, 0));
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h01, 48'h0800_0000_FFFF, 6, 3, 8'hFF, 1, 21'h107FF, 0));
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h01, 48'h0000_F7FF_0001, 8, 0, 8'hFF, 0, 21'h0, 0));
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h01, 48'h0800_F7FF_0001, 8, 0, 8'h7F, 0, 21'h0, 0));
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h01, 48'h0800_1234_0002, 6, 0, 8'hFF, 1, 21'h00802, 0));
    vecs.push_back(mkv(16'h0800, 8'h46, 8'h01, 48'h0800_F7FF_0001, 8, 0, 8'hFF, 0, 21'h0, 0));
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h01, 48'h0800_F7FF_0001, 5, 0, 8'hFF, 0, 21'h0, 0));
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h01, 48'h0800_5555_0100, 8, 0, 8'hFF, 1, 21'h00900, 1));
    vecs.push_back(mkv(16'h0800, 8'h45, 8'h01, 48'h0800_0000_7000, 8, 0, 8'hFF, 1, 21'h07800, 0));

    foreach (vecs[i]) begin
      expect_frame(vecs[i]);
      send_frame(vecs[i]);
    end
    idle(4);
    check("mid_icmp_cnt", 32'(icmp_cnt), 32'd6);
    check("mid_drop_cnt", 32'(drop_cnt), 32'd7);

    // Reset lands on beat 6 of a qualifying frame; window is cut to beats 5..6.
    v = mkv(16'h0800, 8'h45, 8'h01, 48'h0800_0000_0003, 8, 0, 8'hFF, 1, 21'h00803, 0);
    expect_frame(v);
    q_win[q_win.size()-1] = 2;
    for (int k = 0; k < 6; k++) send_beat(make_beat(k, v), 1'b0, 8'hFF);
    rst_window = 1'b1;
    rst = 1'b1;
    send_beat(make_beat(6, v), 1'b0, 8'hFF);
    rst = 1'b0;
    check_all_zero("midframe_reset");
    exp_icmp = 0;
    exp_drop = 0;
    idle(2);
    rst_window = 1'b0;

    v = mkv(16'h0800, 8'h45, 8'h01, 48'h0800_FFFF_1111, 8, 0, 8'hFF, 1, 21'h01911, 0);
    expect_frame(v);
    send_frame(v);
    v = mkv(16'h0800, 8'h45, 8'h11, 48'h0800_FFFF_1111, 8, 0, 8'hFF, 0, 21'h0, 0);
    expect_frame(v);
    send_frame(v);
    idle(10);

    check("final_icmp_cnt", 32'(icmp_cnt), 32'd1);
    check("final_drop_cnt", 32'(drop_cnt), 32'd1);
    check("seed_queue_left", 32'(q_seed.size()), 32'd0);
    check("win_queue_left", 32'(q_win.size()), 32'd0);
    check("drop_queue_left", 32'(q_drop.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
